// File: rtl/jtsdram_bank_tester.sv
// ============================================================================
// Module   : jtsdram_bank_tester
// Purpose  : Per-bank SDRAM pattern tester. Writes an LFSR sequence across a
//            2^SPAN word window of each bank, reads it back and compares,
//            keeping sticky per-bank fail flags and saturating error counts.
// Options  : define JTSDRAM_FAILADDR_EN to add the fail_addr output, which
//            holds each bank's first mismatching address per run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtsdram_bank_tester #(
  parameter int          BANKS = 4,
  parameter int          AW    = 22,
  parameter int          SPAN  = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          TMO   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop,
  output logic                  busy,
  output logic                  done,
  output logic [BANKS-1:0]      ba_rd,
  output logic [BANKS-1:0]      ba_wr,
  output logic [BANKS*AW-1:0]   ba_addr,
  output logic [15:0]           ba_din,
  output logic [1:0]            ba_din_m,
  input  logic [BANKS-1:0]      ba_ack,
  input  logic [BANKS-1:0]      ba_rdy,
  input  logic [15:0]           data_read,
  output logic [BANKS-1:0]      bad,
  output logic [BANKS*8-1:0]    err_cnt,
  output logic [15:0]           pass_cnt
`ifdef JTSDRAM_FAILADDR_EN
  ,
  output logic [BANKS*AW-1:0]   fail_addr
`endif
);

  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TMO);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WREQ  = 3'd1,
    WWAIT = 3'd2,
    RREQ  = 3'd3,
    RWAIT = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   bank;
  logic [SPAN-1:0] idx;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_step;
  logic [TW-1:0]   tmo_cnt;

  logic sel_ack, sel_rdy, tmo_hit, last_idx, last_bank;
  logic clr, acc_done, err_hit, mis_hit;

  // Per-pass seed: a zero seed would lock the LFSR, so fall back to SEED
  function automatic logic [15:0] seed_of(input logic [15:0] p);
    logic [15:0] s;
    s = SEED ^ p;
    return (s == 16'h0000) ? SEED : s;
  endfunction

  assign sel_ack   = ba_ack[bank];
  assign sel_rdy   = ba_rdy[bank];
  assign tmo_hit   = (tmo_cnt == TMO_LIM);
  assign last_idx  = (idx == {SPAN{1'b1}});
  assign last_bank = (bank == LAST_BANK);
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  assign busy     = (state != IDLE);
  assign done     = (state == NEXT) && last_bank;
  assign ba_din   = lfsr;
  assign ba_din_m = 2'b00;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-cycle strobes; a timeout completes the access as an error
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    acc_done = 1'b0;
    err_hit  = 1'b0;
    mis_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = WREQ;
        end
      end
      WREQ: begin
        if (sel_ack) begin
          if (sel_rdy) begin
            acc_done = 1'b1;
            state_nx = last_idx ? RREQ : WREQ;
          end else begin
            state_nx = WWAIT;
          end
        end else if (tmo_hit) begin
          acc_done = 1'b1;
          err_hit  = 1'b1;
          state_nx = last_idx ? RREQ : WREQ;
        end
      end
      WWAIT: begin
        if (sel_rdy || tmo_hit) begin
          acc_done = 1'b1;
          err_hit  = !sel_rdy;
          state_nx = last_idx ? RREQ : WREQ;
        end
      end
      RREQ: begin
        if (sel_ack) begin
          if (sel_rdy) begin
            acc_done = 1'b1;
            mis_hit  = (data_read != lfsr);
            err_hit  = mis_hit;
            state_nx = last_idx ? NEXT : RREQ;
          end else begin
            state_nx = RWAIT;
          end
        end else if (tmo_hit) begin
          acc_done = 1'b1;
          err_hit  = 1'b1;
          state_nx = last_idx ? NEXT : RREQ;
        end
      end
      RWAIT: begin
        if (sel_rdy) begin
          acc_done = 1'b1;
          mis_hit  = (data_read != lfsr);
          err_hit  = mis_hit;
          state_nx = last_idx ? NEXT : RREQ;
        end else if (tmo_hit) begin
          acc_done = 1'b1;
          err_hit  = 1'b1;
          state_nx = last_idx ? NEXT : RREQ;
        end
      end
      NEXT: begin
        state_nx = (last_bank && !loop) ? IDLE : WREQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request strobes and addresses: only the selected bank is driven
  always_comb begin
    ba_wr   = '0;
    ba_rd   = '0;
    ba_addr = '0;
    ba_wr[bank] = (state == WREQ);
    ba_rd[bank] = (state == RREQ);
    ba_addr[bank*AW +: AW] = AW'(idx);
  end

  // Wait-cycle counter, restarted on every new access or state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_nx != state || acc_done || state == IDLE || state == NEXT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Datapath: bank/index walk, LFSR sequencing, error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank     <= '0;
      idx      <= '0;
      lfsr     <= '0;
      bad      <= '0;
      err_cnt  <= '0;
      pass_cnt <= '0;
    end else begin
      if (clr) begin
        bank     <= '0;
        idx      <= '0;
        lfsr     <= seed_of(16'h0000);
        bad      <= '0;
        err_cnt  <= '0;
        pass_cnt <= '0;
      end
      if (acc_done) begin
        if (last_idx) begin
          idx  <= '0;
          lfsr <= seed_of(pass_cnt);
        end else begin
          idx  <= idx + SPAN'(1);
          lfsr <= lfsr_step;
        end
      end
      if (err_hit) begin
        bad[bank] <= 1'b1;
        if (err_cnt[bank*8 +: 8] != 8'hFF)
          err_cnt[bank*8 +: 8] <= err_cnt[bank*8 +: 8] + 8'd1;
      end
      if (state == NEXT) begin
        if (last_bank) begin
          bank     <= '0;
          pass_cnt <= pass_cnt + 16'd1;
          lfsr     <= seed_of(pass_cnt + 16'd1);
        end else begin
          bank <= bank + BW'(1);
          lfsr <= seed_of(pass_cnt);
        end
      end
    end
  end

`ifdef JTSDRAM_FAILADDR_EN
  logic [BANKS-1:0] fa_seen;

  // First mismatching address per bank, captured once per run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_seen   <= '0;
      fail_addr <= '0;
    end else if (clr) begin
      fa_seen   <= '0;
      fail_addr <= '0;
    end else if (mis_hit && !fa_seen[bank]) begin
      fa_seen[bank]            <= 1'b1;
      fail_addr[bank*AW +: AW] <= AW'(idx);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtsdram_bank_tester.sv
// ============================================================================
// Module   : tb_jtsdram_bank_tester
// Purpose  : Directed bench for jtsdram_bank_tester with a small SDRAM model
//            (ack one cycle after request, rdy two cycles after ack).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtsdram_bank_tester;

  localparam int          BANKS = 4;
  localparam int          AW    = 22;
  localparam int          SPAN  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          TMO   = 1023;

  logic                clk = 1'b0;
  logic                rst_n, start, loop;
  logic                busy, done;
  logic [BANKS-1:0]    ba_rd, ba_wr, ba_ack, ba_rdy, bad;
  logic [BANKS*AW-1:0] ba_addr;
  logic [15:0]         ba_din, data_read, pass_cnt;
  logic [1:0]          ba_din_m;
  logic [BANKS*8-1:0]  err_cnt;
`ifdef JTSDRAM_FAILADDR_EN
  logic [BANKS*AW-1:0] fail_addr;
`endif

  jtsdram_bank_tester #(
    .BANKS(BANKS), .AW(AW), .SPAN(SPAN), .SEED(SEED), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
    .busy(busy), .done(done),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_addr(ba_addr),
    .ba_din(ba_din), .ba_din_m(ba_din_m),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read),
    .bad(bad), .err_cnt(err_cnt), .pass_cnt(pass_cnt)
`ifdef JTSDRAM_FAILADDR_EN
    , .fail_addr(fail_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model state
  logic [15:0] mem [4][4];
  logic [7:0]  wcnt [4];
  logic [7:0]  rcnt [4];
  logic [15:0] first_din [$];
  logic [15:0] b0_din [$];
  bit          pend, is_rd;
  int          cnt, cb, ca;
  int          viol, stall_cyc;
  bit          stall_b1, corrupt_one, corrupt_all;

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      wcnt[i] = 8'd0;
      rcnt[i] = 8'd0;
    end
    first_din.delete();
    b0_din.delete();
    viol      = 0;
    stall_cyc = 0;
  endtask

  // Memory model, evaluated on the falling edge so DUT outputs are settled
  always @(negedge clk) begin : p_model
    int          nreq, b;
    logic [AW-1:0] a;
    logic [15:0] d;
    ba_ack = '0;
    ba_rdy = '0;
    if (!rst_n) begin
      pend = 1'b0;
      cnt  = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ba_rdy[cb] = 1'b1;
          pend = 1'b0;
          if (is_rd) begin
            d = mem[cb][ca];
            if (corrupt_all || (corrupt_one && cb == 2 && ca == 3)) d = d ^ 16'h0001;
            data_read = d;
            rcnt[cb]++;
          end
        end
      end
      nreq = $countones(ba_wr) + $countones(ba_rd);
      if (nreq > 1) viol++;
      if (nreq == 1) begin
        b = 0;
        for (int k = 0; k < BANKS; k++) if (ba_wr[k] || ba_rd[k]) b = k;
        for (int k = 0; k < BANKS; k++)
          if (k != b && ba_addr[k*AW +: AW] != '0) viol++;
        if (ba_din_m != 2'b00) viol++;
        a = ba_addr[b*AW +: AW];
        if (a >= 4) viol++;
        if (stall_b1 && ba_rd[1] && a == '0) begin
          stall_cyc++;
        end else if (!pend) begin
          ba_ack[b] = 1'b1;
          pend  = 1'b1;
          cnt   = 2;
          cb    = b;
          ca    = int'(a[1:0]);
          is_rd = ba_rd[b];
          if (ba_wr[b]) begin
            mem[b][ca] = ba_din;
            wcnt[b]++;
            if (b == 0 && ca == 0) first_din.push_back(ba_din);
            if (b == 0 && b0_din.size() < 4) b0_din.push_back(ba_din);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok, output int nd);
    ok = 1'b0;
    nd = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done_n(input int n, input int maxc, output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) c++;
      if (c == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int nd;
    rst_n = 1'b0; start = 1'b0; loop = 1'b0;
    stall_b1 = 1'b0; corrupt_one = 1'b0; corrupt_all = 1'b0;
    data_read = 16'h0000;
    clear_model();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",   busy,    0);
    chk("rst_done",   done,    0);
    chk("rst_req",    {ba_wr, ba_rd}, 0);
    chk("rst_din",    ba_din,  0);
    chk("rst_bad",    bad,     0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_pass",   pass_cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // Clean single pass
    clear_model();
    pulse_start();
    wait_idle(2000, ok, nd);
    chk("a_idle",    ok, 1);
    chk("a_done_n",  nd, 1);
    chk("a_pass",    pass_cnt, 1);
    chk("a_bad",     bad, 0);
    chk("a_errcnt",  err_cnt, 0);
    chk("a_wr_cnt",  {wcnt[3], wcnt[2], wcnt[1], wcnt[0]}, 32'h04040404);
    chk("a_rd_cnt",  {rcnt[3], rcnt[2], rcnt[1], rcnt[0]}, 32'h04040404);
    chk("a_viol",    viol, 0);
    chk("a_din0",    b0_din[0], 16'hACE1);
    chk("a_din1",    b0_din[1], 16'hE270);
    chk("a_din2",    b0_din[2], 16'h7138);
    chk("a_din3",    b0_din[3], 16'h389C);

    // Corrupt bank 2, address 3 on read
    clear_model();
    corrupt_one = 1'b1;
    pulse_start();
    wait_idle(2000, ok, nd);
    corrupt_one = 1'b0;
    chk("b_idle",   ok, 1);
    chk("b_errcnt", err_cnt, 32'h0001_0000);
    chk("b_bad",    bad, 4'b0100);
    chk("b_pass",   pass_cnt, 1);
`ifdef JTSDRAM_FAILADDR_EN
    chk("b_failaddr", fail_addr[2*AW +: AW], 3);
`endif

    // Bank 1 never acks the first read: timeout after TMO+1 cycles
    clear_model();
    stall_b1 = 1'b1;
    pulse_start();
    wait_idle(5000, ok, nd);
    stall_b1 = 1'b0;
    chk("c_idle",      ok, 1);
    chk("c_done_n",    nd, 1);
    chk("c_stall_cyc", stall_cyc, 1024);
    chk("c_errcnt",    err_cnt, 32'h0000_0100);
    chk("c_bad",       bad, 4'b0010);
    chk("c_rd_cnt",    {rcnt[3], rcnt[2], rcnt[1], rcnt[0]}, 32'h04040304);

    // Three looped passes
    clear_model();
    loop = 1'b1;
    pulse_start();
    wait_done_n(2, 3000, ok);
    chk("d_two_done", ok, 1);
    @(negedge clk) loop = 1'b0;
    wait_idle(2000, ok, nd);
    chk("d_idle",  ok, 1);
    chk("d_pass",  pass_cnt, 3);
    chk("d_bad",   bad, 0);
    chk("d_seed0", first_din[0], 16'hACE1);
    chk("d_seed1", first_din[1], 16'hACE0);
    chk("d_seed2", first_din[2], 16'hACE3);

    // Asynchronous reset in the middle of a write request
    clear_model();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ba_wr != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("e_saw_wreq", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("e_req_zero", {ba_wr, ba_rd}, 0);
    chk("e_busy",     busy, 0);
    chk("e_din",      ba_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    pulse_start();
    wait_idle(2000, ok, nd);
    chk("e_idle",   ok, 1);
    chk("e_pass",   pass_cnt, 1);
    chk("e_errcnt", err_cnt, 0);
    chk("e_wr_cnt", {wcnt[3], wcnt[2], wcnt[1], wcnt[0]}, 32'h04040404);

    // Every read corrupted over 64 passes: 256 errors per bank saturate
    clear_model();
    corrupt_all = 1'b1;
    loop = 1'b1;
    pulse_start();
    wait_done_n(63, 12000, ok);
    chk("f_63_done", ok, 1);
    @(negedge clk) loop = 1'b0;
    wait_idle(2000, ok, nd);
    corrupt_all = 1'b0;
    chk("f_idle",   ok, 1);
    chk("f_pass",   pass_cnt, 64);
    chk("f_errcnt", err_cnt, 32'hFFFF_FFFF);
    chk("f_bad",    bad, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
